bcd_counter_ndigit: RTL

Parametrised N-digit BCD counter, the successor to the two-digit display counter. Adds count enable, up/down direction, synchronous clear and load with BCD validation, and a registered wrap pulse for cascading. Drives the seven-segment scan/decoder path, one nibble per digit, and serves as a stopwatch, timer or event counter.

---
 rtl/bcd_counter_ndigit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bcd_counter_ndigit.sv
// N-digit BCD up/down counter with clear, validated load and a registered wrap pulse.
// Define BCD_CNT_LIMIT_EN to add a `limit` port that replaces the all-9s terminal value.
module bcd_counter_ndigit #(
    parameter  int DIGITS = 4,
    localparam int W      = 4 * DIGITS
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
`ifdef BCD_CNT_LIMIT_EN
    input  logic [W-1:0] limit,
`endif
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         load_err,
    output logic         at_zero
);

    logic [W-1:0] r_count;
    logic         r_wrap;
    logic         r_load_err;

    logic [W-1:0] w_max;
    logic [W-1:0] w_load_fix;
    logic         w_load_bad;
    logic [W-1:0] w_inc;
    logic [W-1:0] w_dec;
    logic         w_at_max;
    logic         w_is_zero;
    logic [W-1:0] w_next;
    logic         w_next_wrap;
    logic         w_next_err;

`ifdef BCD_CNT_LIMIT_EN
    // Out-of-range limit digits saturate to 9 so the terminal value is always valid BCD.
    always_comb begin
        w_max = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_max[4*i +: 4] = (limit[4*i +: 4] > 4'd9) ? 4'd9 : limit[4*i +: 4];
        end
    end
`else
    assign w_max = {DIGITS{4'h9}};
`endif

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_load_fix = '0;
        w_load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                w_load_bad = 1'b1;
            end else begin
                w_load_fix[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // Single-cycle ripple of carry (up) and borrow (down) through all digits.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] digit;
        w_inc  = '0;
        w_dec  = '0;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            digit = r_count[4*i +: 4];
            if (!carry) begin
                w_inc[4*i +: 4] = digit;
            end else if (digit == 4'd9) begin
                w_inc[4*i +: 4] = 4'd0;
            end else begin
                w_inc[4*i +: 4] = digit + 4'd1;
                carry           = 1'b0;
            end
            if (!borrow) begin
                w_dec[4*i +: 4] = digit;
            end else if (digit == 4'd0) begin
                w_dec[4*i +: 4] = 4'd9;
            end else begin
                w_dec[4*i +: 4] = digit - 4'd1;
                borrow          = 1'b0;
            end
        end
    end

    // BCD vectors order the same as their decimal values, so a plain unsigned compare works.
    assign w_at_max  = (r_count >= w_max);
    assign w_is_zero = (r_count == '0);

    always_comb begin
        w_next      = r_count;
        w_next_wrap = 1'b0;
        w_next_err  = 1'b0;
        if (clear) begin
            w_next = '0;
        end else if (load) begin
            w_next     = w_load_fix;
            w_next_err = w_load_bad;
        end else if (en) begin
            if (up) begin
                if (w_at_max) begin
                    w_next      = '0;
                    w_next_wrap = 1'b1;
                end else begin
                    w_next = w_inc;
                end
            end else begin
                if (w_is_zero) begin
                    w_next      = w_max;
                    w_next_wrap = 1'b1;
                end else begin
                    w_next = w_dec;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_next;
            r_wrap     <= w_next_wrap;
            r_load_err <= w_next_err;
        end
    end

    assign count    = r_count;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;
    assign at_zero  = w_is_zero;

endmodule
